// File: rtl/lstm_pkg.sv
// Shared types and constants for the LSTM backward-pass sequencer and its accumulators.
package lstm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitRd,
    StWaitD,
    StDone
  } state_e;

  localparam int unsigned GATE_A    = 0;
  localparam int unsigned GATE_I    = 1;
  localparam int unsigned GATE_F    = 2;
  localparam int unsigned GATE_O    = 3;
  localparam int unsigned NUM_GATES = 4;

  // Two's-complement bit patterns of the largest and smallest signed value in 'width' bits.
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sat_acc.sv
// Signed saturating accumulator with synchronous clear and add-enable.
module sat_acc
  import lstm_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] acc
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MinVal = WIDTH'(sat_min(WIDTH));

  logic [WIDTH-1:0] acc_q, acc_d, sum;
  logic             ovf;

  always_comb begin
    sum   = acc_q + din;
    // Overflow only when both operands share a sign that the sum does not.
    ovf   = (acc_q[WIDTH-1] == din[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = ovf ? (din[WIDTH-1] ? MinVal : MaxVal) : sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/bptt_seq.sv
// Reverse-time sequencer driving one shared LSTM delta datapath, carrying dh/dc between
// timesteps and accumulating the four bias gradients with saturation.
module bptt_seq
  import lstm_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned FRAC     = 24,
  parameter int unsigned TIMESTEP = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  output logic                   o_busy,
  output logic                   o_rd_en,
  output logic [IDX_W-1:0]       o_step_idx,
  input  logic                   i_rd_valid,
  output logic                   o_d_go,
  output logic [WIDTH-1:0]       o_d_h_prev,
  output logic [WIDTH-1:0]       o_d_c_prev,
  output logic                   o_last,
  input  logic                   i_d_valid,
  input  logic [4*WIDTH-1:0]     i_dgates,
  input  logic [WIDTH-1:0]       i_d_h_next,
  input  logic [WIDTH-1:0]       i_d_c_next,
  output logic                   o_acc_en,
  output logic [4*WIDTH-1:0]     o_b,
  output logic                   o_done
);

  if (TIMESTEP < 2 || FRAC >= WIDTH || IDX_W != $clog2(TIMESTEP)) begin : g_bad_param
    $error("bptt_seq: inconsistent parameters");
  end

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(TIMESTEP - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] h_q, c_q;
  logic             start_run;

  // Abort overrides everything, so no strobe leaks out in the cycle it is seen.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    start_run = 1'b0;
    o_rd_en   = 1'b0;
    o_d_go    = 1'b0;
    o_acc_en  = 1'b0;
    o_done    = 1'b0;
    if (i_abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            start_run = 1'b1;
            idx_d     = LastIdx;
            state_d   = StFetch;
          end
        end
        StFetch: begin
          o_rd_en = 1'b1;
          state_d = StWaitRd;
        end
        StWaitRd: begin
          if (i_rd_valid) begin
            o_d_go  = 1'b1;
            state_d = StWaitD;
          end
        end
        StWaitD: begin
          if (i_d_valid) begin
            o_acc_en = 1'b1;
            if (idx_q == '0) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q - 1'b1;
              state_d = StFetch;
            end
          end
        end
        StDone: begin
          o_done  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      h_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (start_run) begin
        h_q <= '0;
        c_q <= '0;
      end else if (o_acc_en) begin
        h_q <= i_d_h_next;
        c_q <= i_d_c_next;
      end
    end
  end

  assign o_busy     = (state_q != StIdle);
  assign o_step_idx = idx_q;
  assign o_d_h_prev = h_q;
  assign o_d_c_prev = c_q;
  assign o_last     = o_busy && (idx_q == LastIdx);

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_bias
    sat_acc #(
      .WIDTH(WIDTH)
    ) u_acc (
      .clk (clk),
      .rst (rst),
      .clr (start_run),
      .en  (o_acc_en),
      .din (i_dgates[g*WIDTH +: WIDTH]),
      .acc (o_b[g*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_bptt_seq.sv
// Bench for bptt_seq: plays forward buffer and delta datapath, compares against a step model.
module tb_bptt_seq;

  localparam int WIDTH = 32;
  localparam int FRAC  = 24;
  localparam int T     = 4;
  localparam int IDX_W = 2;
  localparam longint MaxS = (longint'(1) <<< (WIDTH - 1)) - 1;
  localparam longint MinS = -(longint'(1) <<< (WIDTH - 1));

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               i_start = 1'b0, i_abort = 1'b0, i_rd_valid = 1'b0, i_d_valid = 1'b0;
  logic [4*WIDTH-1:0] i_dgates = '0;
  logic [WIDTH-1:0]   i_d_h_next = '0, i_d_c_next = '0;
  logic               o_busy, o_rd_en, o_d_go, o_last, o_acc_en, o_done;
  logic [IDX_W-1:0]   o_step_idx;
  logic [WIDTH-1:0]   o_d_h_prev, o_d_c_prev;
  logic [4*WIDTH-1:0] o_b;

  bptt_seq #(
    .WIDTH(WIDTH), .FRAC(FRAC), .TIMESTEP(T), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .o_busy(o_busy),
    .o_rd_en(o_rd_en), .o_step_idx(o_step_idx), .i_rd_valid(i_rd_valid), .o_d_go(o_d_go),
    .o_d_h_prev(o_d_h_prev), .o_d_c_prev(o_d_c_prev), .o_last(o_last), .i_d_valid(i_d_valid),
    .i_dgates(i_dgates), .i_d_h_next(i_d_h_next), .i_d_c_next(i_d_c_next),
    .o_acc_en(o_acc_en), .o_b(o_b), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-step data the bench returns, indexed by timestep.
  logic [4*WIDTH-1:0] dg [T];
  logic [WIDTH-1:0]   hn [T];
  logic [WIDTH-1:0]   cn [T];

  // Observations from the last run.
  int               n_go, n_acc, done_n, done_cyc, last_bad;
  bit               timed_out;
  int               go_idx [T];
  int               acc_idx [T];
  logic [WIDTH-1:0] go_h [T];
  logic [WIDTH-1:0] go_c [T];
  bit               go_last [T];

  // Saturating per-gate sum over timesteps T-1 down to lo.
  function automatic logic [4*WIDTH-1:0] exp_bias(input int lo);
    logic [4*WIDTH-1:0] r;
    logic [WIDTH-1:0]   w;
    longint             s;
    r = '0;
    for (int g = 0; g < 4; g++) begin
      s = 0;
      for (int k = T - 1; k >= lo; k--) begin
        w = dg[k][g*WIDTH +: WIDTH];
        s = s + longint'($signed(w));
        if (s > MaxS) s = MaxS;
        else if (s < MinS) s = MinS;
      end
      r[g*WIDTH +: WIDTH] = s[WIDTH-1:0];
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] exp_h(input int i);
    return (i == 0) ? '0 : hn[T - i];
  endfunction

  function automatic logic [WIDTH-1:0] exp_c(input int i);
    return (i == 0) ? '0 : cn[T - i];
  endfunction

  task automatic set_basic();
    for (int k = 0; k < T; k++) begin
      dg[k] = {32'h0100_0000, 32'h0080_0000, 32'h0040_0000, 32'h0020_0000};
      hn[k] = WIDTH'(k + 1);
      cn[k] = WIDTH'(10 * (k + 1));
    end
  endtask

  task automatic zero_inputs();
    i_start = 0; i_abort = 0; i_rd_valid = 0; i_d_valid = 0;
    i_dgates = '0; i_d_h_next = '0; i_d_c_next = '0;
  endtask

  // kill_kind: 0 none, 1 abort, 2 reset; applied in the WAIT_D cycle of step kill_idx.
  task automatic run(input int rd_lat, input int d_lat, input bit spurious,
                     input bit start_busy, input int kill_idx, input int kill_kind);
    int rd_cnt, d_cnt, d_k, post, kill_stage;
    bit start_pend, kill_pend;
    rd_cnt = 0; d_cnt = 0; d_k = 0; post = 0; kill_stage = 0;
    start_pend = 0; kill_pend = 0;
    n_go = 0; n_acc = 0; done_n = 0; done_cyc = -1; last_bad = 0; timed_out = 0;
    @(posedge clk); #1; i_start = 1;
    @(posedge clk); #1; i_start = 0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk);
      if (kill_stage == 2) return;
      if (o_d_go) begin
        if (n_go < T) begin
          go_idx[n_go] = int'(o_step_idx); go_h[n_go] = o_d_h_prev;
          go_c[n_go] = o_d_c_prev; go_last[n_go] = o_last;
        end
        n_go++;
        d_cnt = d_lat;
        d_k = int'(o_step_idx);
        if (start_busy && int'(o_step_idx) == 2) start_pend = 1;
        if (kill_kind != 0 && int'(o_step_idx) == kill_idx) kill_pend = 1;
      end
      if (o_acc_en) begin
        if (n_acc < T) acc_idx[n_acc] = int'(o_step_idx);
        n_acc++;
      end
      if (o_last && int'(o_step_idx) != T - 1) last_bad++;
      if (o_done) begin done_n++; done_cyc = cyc; end
      if (o_rd_en) rd_cnt = rd_lat;
      if (done_n > 0) begin
        post++;
        if (post > 2) return;
      end
      @(posedge clk); #1;
      if (kill_stage == 1) begin
        zero_inputs(); rst = 1; kill_stage = 2;
        continue;
      end
      i_rd_valid = (rd_cnt == 1);
      if (rd_cnt > 0) rd_cnt--;
      i_d_valid  = (d_cnt == 1);
      i_dgates   = dg[d_k]; i_d_h_next = hn[d_k]; i_d_c_next = cn[d_k];
      if (d_cnt > 0) d_cnt--;
      if (spurious && rd_cnt == 2) begin
        i_d_valid = 1; i_dgates = {4{32'h5A5A_5A5A}};
        i_d_h_next = 32'hDEAD_0001; i_d_c_next = 32'hDEAD_0002;
      end
      i_start = start_pend; start_pend = 0;
      if (kill_pend) begin
        kill_pend = 0; kill_stage = 1;
        if (kill_kind == 1) i_abort = 1;
        else rst = 0;
      end
    end
    timed_out = 1;
    zero_inputs();
  endtask

  task automatic test_reset();
    rst = 0; zero_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({o_busy, o_rd_en, o_d_go, o_last, o_acc_en, o_done, o_step_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 0",
               {o_busy, o_rd_en, o_d_go, o_last, o_acc_en, o_done, o_step_idx});
    end
    n_checks++;
    if ({o_d_h_prev, o_d_c_prev, o_b} !== '0) begin
      n_fail++; $display("FAIL reset_data got %h want 0", {o_d_h_prev, o_d_c_prev, o_b});
    end
    @(posedge clk); #1; rst = 1;
  endtask

  task automatic test_basic();
    set_basic();
    run(1, 1, 0, 0, -1, 0);
    n_checks++;
    if (timed_out || done_n !== 1) begin
      n_fail++; $display("FAIL basic_done got count=%0d timeout=%0d want 1", done_n, timed_out);
    end
    n_checks++;
    if (done_cyc !== 3 * T + 1) begin
      n_fail++; $display("FAIL basic_latency got %0d want %0d", done_cyc, 3 * T + 1);
    end
    n_checks++;
    if (n_go !== T || n_acc !== T) begin
      n_fail++; $display("FAIL basic_issues got go=%0d acc=%0d want %0d", n_go, n_acc, T);
    end
    for (int i = 0; i < T; i++) begin
      n_checks++;
      if (go_idx[i] !== T - 1 - i || acc_idx[i] !== T - 1 - i) begin
        n_fail++;
        $display("FAIL basic_idx[%0d] got go=%0d acc=%0d want %0d", i, go_idx[i], acc_idx[i],
                 T - 1 - i);
      end
      n_checks++;
      if (go_last[i] !== (i == 0)) begin
        n_fail++; $display("FAIL basic_last[%0d] got %0d want %0d", i, go_last[i], i == 0);
      end
      n_checks++;
      if (go_h[i] !== exp_h(i) || go_c[i] !== exp_c(i)) begin
        n_fail++;
        $display("FAIL carry[%0d] got h=%0d c=%0d want h=%0d c=%0d", i, go_h[i], go_c[i],
                 exp_h(i), exp_c(i));
      end
    end
    n_checks++;
    if (last_bad !== 0) begin
      n_fail++; $display("FAIL basic_last_stray got %0d want 0", last_bad);
    end
    n_checks++;
    if (o_b !== {32'h0400_0000, 32'h0200_0000, 32'h0100_0000, 32'h0080_0000}) begin
      n_fail++; $display("FAIL basic_bias got %h want 04000000020000000100000000800000", o_b);
    end
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle got busy=%0d want 0", o_busy);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < T; k++) dg[k] = {32'h0, 32'h0, 32'h8100_0000, 32'h7F00_0000};
    run(1, 1, 0, 0, -1, 0);
    n_checks++;
    if (o_b[31:0] !== 32'h7FFF_FFFF || o_b[63:32] !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL sat_clip got ba=%h bi=%h want 7fffffff 80000000", o_b[31:0], o_b[63:32]);
    end
    n_checks++;
    if (o_b !== exp_bias(0)) begin
      n_fail++; $display("FAIL sat_bias got %h want %h", o_b, exp_bias(0));
    end
  endtask

  task automatic test_var_latency();
    set_basic();
    run(5, 1, 1, 0, -1, 0);
    n_checks++;
    if (timed_out || done_n !== 1 || done_cyc !== T * 7 + 1) begin
      n_fail++;
      $display("FAIL varlat_done got count=%0d cyc=%0d want 1 %0d", done_n, done_cyc, T * 7 + 1);
    end
    n_checks++;
    if (o_b !== exp_bias(0)) begin
      n_fail++; $display("FAIL varlat_bias got %h want %h", o_b, exp_bias(0));
    end
    for (int i = 0; i < T; i++) begin
      n_checks++;
      if (go_h[i] !== exp_h(i) || go_c[i] !== exp_c(i)) begin
        n_fail++;
        $display("FAIL varlat_carry[%0d] got %h %h want %h %h", i, go_h[i], go_c[i],
                 exp_h(i), exp_c(i));
      end
    end
  endtask

  task automatic test_abort();
    set_basic();
    run(1, 3, 0, 0, 1, 1);
    n_checks++;
    if (o_busy !== 1'b0 || done_n !== 0) begin
      n_fail++; $display("FAIL abort_idle got busy=%0d done=%0d want 0 0", o_busy, done_n);
    end
    n_checks++;
    if (o_b !== exp_bias(2)) begin
      n_fail++; $display("FAIL abort_partial got %h want %h", o_b, exp_bias(2));
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
        n_fail++; $display("FAIL abort_quiet got done=%0d busy=%0d want 0 0", o_done, o_busy);
      end
    end
    @(posedge clk); #1; i_start = 1; i_abort = 1;
    @(posedge clk); #1; i_start = 0; i_abort = 0;
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL start_abort got busy=%0d rd=%0d want 0 0", o_busy, o_rd_en);
    end
  endtask

  task automatic test_reset_mid();
    set_basic();
    run(1, 1, 0, 0, 2, 2);
    n_checks++;
    if ({o_busy, o_rd_en, o_d_go, o_last, o_acc_en, o_done, o_step_idx,
         o_d_h_prev, o_d_c_prev, o_b} !== '0) begin
      n_fail++;
      $display("FAIL midreset_zero got busy=%0d idx=%0d h=%h b=%h want all 0",
               o_busy, o_step_idx, o_d_h_prev, o_b);
    end
    run(1, 1, 0, 0, -1, 0);
    n_checks++;
    if (done_n !== 1 || done_cyc !== 3 * T + 1 || o_b !== exp_bias(0)) begin
      n_fail++;
      $display("FAIL midreset_rerun got done=%0d cyc=%0d b=%h want 1 %0d %h",
               done_n, done_cyc, o_b, 3 * T + 1, exp_bias(0));
    end
  endtask

  task automatic test_start_busy();
    set_basic();
    run(1, 1, 0, 1, -1, 0);
    n_checks++;
    if (done_n !== 1 || done_cyc !== 3 * T + 1 || n_go !== T) begin
      n_fail++;
      $display("FAIL busy_start got done=%0d cyc=%0d go=%0d want 1 %0d %0d",
               done_n, done_cyc, n_go, 3 * T + 1, T);
    end
    n_checks++;
    if (o_b !== exp_bias(0)) begin
      n_fail++; $display("FAIL busy_start_bias got %h want %h", o_b, exp_bias(0));
    end
  endtask

  task automatic test_random();
    int rl, dl;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < T; k++) begin
        dg[k] = {$urandom, $urandom, $urandom, $urandom};
        if (it % 2 == 0) dg[k] = dg[k] >> 3;
        hn[k] = $urandom; cn[k] = $urandom;
      end
      rl = int'($urandom_range(1, 4));
      dl = int'($urandom_range(1, 4));
      run(rl, dl, rl >= 3, 0, -1, 0);
      n_checks++;
      if (done_n !== 1 || done_cyc !== T * (1 + rl + dl) + 1) begin
        n_fail++;
        $display("FAIL rand%0d_done got %0d cyc=%0d want 1 %0d", it, done_n, done_cyc,
                 T * (1 + rl + dl) + 1);
      end
      n_checks++;
      if (o_b !== exp_bias(0)) begin
        n_fail++; $display("FAIL rand%0d_bias got %h want %h", it, o_b, exp_bias(0));
      end
      for (int i = 0; i < T; i++) begin
        n_checks++;
        if (go_h[i] !== exp_h(i) || go_c[i] !== exp_c(i)) begin
          n_fail++;
          $display("FAIL rand%0d_carry[%0d] got %h %h want %h %h", it, i, go_h[i], go_c[i],
                   exp_h(i), exp_c(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_var_latency();
    test_abort();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no end of test want completion");
    $fatal(1);
  end

endmodule
